led_blink_driver: RTL and testbench
===================================

# led_blink_driver

Output-side counterpart to the pushbutton input conditioning: it turns single-cycle internal event strobes into human-visible LED blinks on an FPGA pin. Each accepted event produces exactly one blink of fixed on-time followed by a fixed off-gap. Events that arrive while a blink is in progress are queued in a saturating counter and replayed back-to-back. The block sits between register/event logic in the 50 MHz `clk` domain and a board LED pin.

## Interface
Parameters:
- `ON_CYCLES`, default 2_500_000: LED active time per blink, in `clk` cycles (50 ms at 50 MHz). Must be ≥ 1.
- `OFF_CYCLES`, default 2_500_000: mandatory dark gap after every blink, in cycles. Must be ≥ 1.
- `MAX_PENDING`, default 15: queue depth; saturation value of the pending counter. Must be ≥ 1.
- `ACTIVE_LOW`, default 1: when 1, `led` drives 0 for lit and 1 for dark.

Ports:
- `clk` input 1: 50 MHz system clock. Single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `event_stb` input 1: one-cycle request for one blink. Synchronous to `clk`.
- `led` output 1: registered LED pin drive, with polarity set by `ACTIVE_LOW`.
- `busy` output 1: high while the state is not IDLE, or while `pending` ≠ 0.
- `overflow` output 1: one-cycle pulse when an event is dropped because the queue is at saturation.

## Operation
- Reset values: state IDLE, `pending` = 0, timer = 0, `led` = dark (1 if `ACTIVE_LOW`, else 0), `busy` = 0, `overflow` = 0.
- States:
  - IDLE: LED dark.
  - ON: LED lit; the timer counts `ON_CYCLES`.
  - OFF: LED dark; the timer counts `OFF_CYCLES`.
- IDLE → ON occurs when `event_stb` = 1 or `pending` > 0.
  - A fresh strobe in IDLE starts the blink directly; it never enters the queue.
  - If `pending` > 0 in IDLE (not reachable in normal flow), decrement `pending` and go to ON.
- ON → OFF after exactly `ON_CYCLES` cycles in ON.
- OFF → ON after exactly `OFF_CYCLES` cycles, if `pending` > 0 or `event_stb` = 1. Otherwise OFF → IDLE.
  - When the blink starts from `pending`, decrement `pending`.
  - When it starts from a same-cycle strobe, consume the strobe directly.
- Pending counter:
  - Width is `$clog2(MAX_PENDING+1)`.
  - A strobe that does not start a blink increments `pending`.
  - If `pending` is already `MAX_PENDING`, the strobe is dropped and `overflow` pulses on the next cycle.
- Simultaneous strobe and queue consumption in the same cycle: net `pending` is unchanged, and no overflow is flagged even at saturation.
- Timer:
  - Down-counter, width `$clog2(max(ON_CYCLES,OFF_CYCLES)+1)`.
  - Loaded with N−1 on entry to ON or OFF; the state exits when the counter reads 0.
  - No wrap-around is permitted.
- Mid-operation reset: `led` goes to dark immediately (asynchronously), and the queue is cleared.

## Timing
- Latency: strobe sampled at edge t in IDLE → `led` lit from edge t+1.
- Blink shape: `led` is lit for exactly `ON_CYCLES` consecutive cycles, then dark for at least `OFF_CYCLES` cycles.
- Back-to-back blinks: the period is exactly `ON_CYCLES + OFF_CYCLES` cycles, with no idle cycle inserted.
- `busy` is registered alongside the state. It is high from t+1 of the first event until the cycle after OFF completes with an empty queue.
- `led` and `overflow` are flop outputs with no combinational path from `event_stb`.

## Structure
- Shared package `led_pkg` contains:
  - the `blink_state_t` enum (IDLE, ON, OFF);
  - the `LED_LIT` / `LED_DARK` helper function taking `ACTIVE_LOW`.
- One natural sub-module: `blink_timer`, a loadable down-counter with a `load`, `value` and `zero` interface.
  - It is reused for both the ON and OFF phases.
- Pending counter and FSM stay in the top module.

## Test plan
Use `ON_CYCLES`=4, `OFF_CYCLES`=3, `MAX_PENDING`=2, `ACTIVE_LOW`=1 unless noted.
- Reset check: assert `rst_n`=0 mid-blink → `led`=1, `busy`=0 and `overflow`=0 immediately; after release, IDLE with no blink.
- Single strobe at cycle 10 → `led`=0 during cycles 11–14, `led`=1 from cycle 15, `busy` falls at cycle 18.
- Three strobes at cycles 10, 12, 13 → three blinks with lit windows starting at 11, 18 and 25. Blinks are contiguous with a period of 7 and no overflow.
- Four strobes during a single blink (cycles 10, 11, 12, 13) → blink 1 from the first strobe; the next two are queued (`pending`=2); the strobe at cycle 13 is dropped with an `overflow` pulse at cycle 14. Three blinks total.
- Saturation interplay: strobe arriving in the same cycle that OFF exits with `pending`=2 → `pending` stays 2 and no `overflow`.
- `ACTIVE_LOW`=0 → same single-strobe timing with `led` polarity inverted (1 while lit).

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink driver: FSM state encoding and
// pin-polarity helpers so the lit/dark levels are defined in one place.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Pin level that lights the LED for the given board polarity.
    function automatic logic led_lit(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    // Pin level that keeps the LED dark for the given board polarity.
    function automatic logic led_dark(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter shared by the ON and OFF phases. It parks at zero
// rather than wrapping, so an idle FSM always sees a quiet timer.
module blink_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/led_blink_driver.sv
// Turns single-cycle event strobes into visible LED blinks of fixed on-time
// followed by a fixed dark gap. Strobes arriving mid-blink are queued in a
// saturating counter and replayed back-to-back; drops pulse overflow.
module led_blink_driver
    import led_pkg::*;
#(
    parameter int ON_CYCLES   = 2_500_000,
    parameter int OFF_CYCLES  = 2_500_000,
    parameter int MAX_PENDING = 15,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic event_stb,
    output logic led,
    output logic busy,
    output logic overflow
);

    localparam bit AL      = (ACTIVE_LOW != 0);
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int PW      = $clog2(MAX_PENDING + 1);

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    blink_state_t    state;
    blink_state_t    state_n;
    logic            start;
    logic [PW-1:0]   pending;
    logic [PW-1:0]   pending_d;
    logic            take;
    logic            add;
    logic            ovf_d;
    logic            led_d;
    logic            busy_d;
    logic            tmr_load;
    logic [TW-1:0]   tmr_load_val;
    logic [TW-1:0]   tmr_value;
    logic            tmr_zero;

    // Saturating queue update: returns {dropped, next_count}. A strobe that
    // coincides with a replay leaves the count unchanged and is never dropped.
    function automatic logic [PW:0] queue_update(input logic [PW-1:0] cur,
                                                 input logic          inc,
                                                 input logic          dec);
        logic [PW-1:0] nxt;
        logic          drop;
        nxt  = cur;
        drop = 1'b0;
        if (inc && !dec) begin
            if (cur == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                nxt = cur + PW'(1);
            end
        end else if (dec && !inc) begin
            nxt = cur - PW'(1);
        end
        return {drop, nxt};
    endfunction

    blink_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: start a blink from idle or at the end of a dark gap when
    // there is queued work or a same-cycle strobe.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (event_stb || (pending != '0)) begin
                    state_n = ON;
                    start   = 1'b1;
                end
            end
            ON: begin
                if (tmr_zero) begin
                    state_n = OFF;
                end
            end
            OFF: begin
                if (tmr_zero) begin
                    if (event_stb || (pending != '0)) begin
                        state_n = ON;
                        start   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Queue bookkeeping: a start drains the queue first; a strobe is consumed
    // directly only when the queue is empty, otherwise it is enqueued.
    always_comb begin
        take = start && (pending != '0);
        add  = event_stb && !(start && (pending == '0));
        {ovf_d, pending_d} = queue_update(pending, add, take);
    end

    // FSM outputs and timer control, all derived from the next state so the
    // registered pins line up with the state they describe.
    always_comb begin
        led_d        = (state_n == ON) ? led_lit(AL) : led_dark(AL);
        busy_d       = (state_n != IDLE) || (pending_d != '0);
        tmr_load     = (state_n != state) && (state_n != IDLE);
        tmr_load_val = (state_n == ON) ? ON_LOAD : OFF_LOAD;
    end

    // Output and queue registers; reset drops the LED dark at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            led      <= led_dark(AL);
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_d;
            led      <= led_d;
            busy     <= busy_d;
            overflow <= ovf_d;
        end
    end

    idle_timer_parked: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE) |-> (tmr_value == '0));

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver with ON=4, OFF=3, MAX_PENDING=2.
// Two instances share stimulus: one active-low pin, one active-high pin.
module tb_led_blink_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic event_stb = 1'b0;
    logic led, busy, overflow;
    logic led_hi, busy_hi, overflow_hi;

    int checks;
    int errors;

    always #10 clk = ~clk;

    led_blink_driver #(
        .ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .event_stb(event_stb),
        .led(led), .busy(busy), .overflow(overflow)
    );

    led_blink_driver #(
        .ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(2), .ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .event_stb(event_stb),
        .led(led_hi), .busy(busy_hi), .overflow(overflow_hi)
    );

    // Bit i of each mask describes cycle offset i from the first strobe.
    typedef struct {
        string       name;
        int          n;
        logic [47:0] stb;
        logic [47:0] lit;
        logic [47:0] bsy;
        logic [47:0] ovf;
        int          pend_off;
        int          pend_val;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [47:0] rng(input int lo, input int hi);
        logic [47:0] m;
        m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string what, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", what, act, exp);
        end
    endtask

    task automatic chk_int(input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", what, act, exp);
        end
    endtask

    task automatic idle(input int n);
        event_stb = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_scn(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            event_stb = v.stb[i];
            @(negedge clk);
            chk($sformatf("%s led @%0d", v.name, i), led, ~v.lit[i]);
            chk($sformatf("%s led_hi @%0d", v.name, i), led_hi, v.lit[i]);
            chk($sformatf("%s busy @%0d", v.name, i), busy, v.bsy[i]);
            chk($sformatf("%s busy_hi @%0d", v.name, i), busy_hi, v.bsy[i]);
            chk($sformatf("%s overflow @%0d", v.name, i), overflow, v.ovf[i]);
            if (i == v.pend_off)
                chk_int($sformatf("%s pending @%0d", v.name, i), int'(dut.pending), v.pend_val);
            @(posedge clk);
            #1;
        end
        event_stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        tbl[0] = '{"single", 10, rng(0,0), rng(1,4), rng(1,7), 48'd0, -1, 0};
        tbl[1] = '{"three", 24, rng(0,0) | rng(2,3),
                   rng(1,4) | rng(8,11) | rng(15,18), rng(1,21), 48'd0, 4, 2};
        tbl[2] = '{"four", 24, rng(0,3),
                   rng(1,4) | rng(8,11) | rng(15,18), rng(1,21), rng(4,4), 4, 2};
        tbl[3] = '{"saturate", 31, rng(0,2) | rng(7,7),
                   rng(1,4) | rng(8,11) | rng(15,18) | rng(22,25), rng(1,28), 48'd0, 8, 2};
        tbl[4] = '{"direct", 16, rng(0,0) | rng(7,7),
                   rng(1,4) | rng(8,11), rng(1,14), 48'd0, 8, 0};

        // Reset state
        #35;
        chk("reset led", led, 1'b1);
        chk("reset led_hi", led_hi, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        for (int s = 0; s < 5; s++) begin
            run_scn(tbl[s]);
            idle(3);
        end

        // Asynchronous reset mid-blink while an overflow pulse is showing
        for (int i = 0; i < 4; i++) begin
            event_stb = 1'b1;
            @(posedge clk);
            #1;
        end
        event_stb = 1'b0;
        chk("pre-reset overflow", overflow, 1'b1);
        chk("pre-reset led", led, 1'b0);
        chk_int("pre-reset pending", int'(dut.pending), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset led", led, 1'b1);
        chk("async reset led_hi", led_hi, 1'b0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset overflow", overflow, 1'b0);
        chk_int("async reset pending", int'(dut.pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset led @%0d", i), led, 1'b1);
            chk($sformatf("post-reset busy @%0d", i), busy, 1'b0);
            chk($sformatf("post-reset overflow @%0d", i), overflow, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
